// File: rtl/tmu2_splitq_if.sv
// Record bundle of the texel-address split stage: upstream record, fragment and fetch channels.
// Carries no logic; the slave modport is the split stage, the master modport its environment.
// Strobes/acks follow the stb/ack handshake: a transfer happens when both are high at an edge.
interface tmu2_splitq_if #(
    parameter int cache_depth = 13,
    parameter int fml_depth   = 26
);
    logic                   pipe_stb_i;
    logic                   pipe_ack_o;
    logic [fml_depth-2:0]   dadr;
    logic [fml_depth-1:0]   tadra, tadrb, tadrc, tadrd;
    logic [5:0]             x_frac, y_frac;
    logic                   miss_a, miss_b, miss_c, miss_d;

    logic                   frag_pipe_stb_o;
    logic                   frag_pipe_ack_i;
    logic [fml_depth-2:0]   frag_dadr;
    logic [cache_depth-1:0] frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd;
    logic [5:0]             frag_x_frac, frag_y_frac;
    logic                   frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d;

    logic                   fetch_pipe_stb_o;
    logic                   fetch_pipe_ack_i;
    logic [fml_depth-6:0]   fetch_tadra, fetch_tadrb, fetch_tadrc, fetch_tadrd;
    logic                   fetch_miss_a, fetch_miss_b, fetch_miss_c, fetch_miss_d;

    modport slave (
        input  pipe_stb_i, dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac,
               miss_a, miss_b, miss_c, miss_d, frag_pipe_ack_i, fetch_pipe_ack_i,
        output pipe_ack_o,
               frag_pipe_stb_o, frag_dadr, frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd,
               frag_x_frac, frag_y_frac, frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d,
               fetch_pipe_stb_o, fetch_tadra, fetch_tadrb, fetch_tadrc, fetch_tadrd,
               fetch_miss_a, fetch_miss_b, fetch_miss_c, fetch_miss_d
    );

    modport master (
        output pipe_stb_i, dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac,
               miss_a, miss_b, miss_c, miss_d, frag_pipe_ack_i, fetch_pipe_ack_i,
        input  pipe_ack_o,
               frag_pipe_stb_o, frag_dadr, frag_tadra, frag_tadrb, frag_tadrc, frag_tadrd,
               frag_x_frac, frag_y_frac, frag_miss_a, frag_miss_b, frag_miss_c, frag_miss_d,
               fetch_pipe_stb_o, fetch_tadra, fetch_tadrb, fetch_tadrc, fetch_tadrd,
               fetch_miss_a, fetch_miss_b, fetch_miss_c, fetch_miss_d
    );
endinterface

// File: rtl/tmu2_splitq.sv
// Splits texel-address records into a fragment queue (all records) and a fetch queue (misses only).
// Latency: a record pushed into an empty queue is presented the cycle after its accept edge.
// Backpressure: upstream ack drops while either queue is full; each queue drains on its own ack.

// Generic show-ahead circular FIFO; head entry is always on dat_o, caller never overflows/underflows.
module tmu2_splitq_fifo #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic [D:0]   level_o
);
    localparam int N = 1 << D;

    logic [W-1:0] mem_q [N];
    logic [D-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [D:0]   level_q, level_d;

    // Next pointer/occupancy values; push+pop together leaves the level untouched
    always_comb begin
        wr_d    = push_i ? wr_q + D'(1) : wr_q;
        rd_d    = pop_i  ? rd_q + D'(1) : rd_q;
        level_d = level_q;
        if (push_i && !pop_i)
            level_d = level_q + (D+1)'(1);
        else if (!push_i && pop_i)
            level_d = level_q - (D+1)'(1);
    end

    // Storage write; entries need no reset since the level gates their visibility
    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_q] <= dat_i;
    end

    // Pointer and occupancy registers with synchronous reset discarding all entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    assign dat_o   = mem_q[rd_q];
    assign level_o = level_q;
endmodule

module tmu2_splitq #(
    parameter int cache_depth = 13,
    parameter int fml_depth   = 26,
    parameter int frag_depth  = 2,
    parameter int fetch_depth = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    tmu2_splitq_if.slave         bus,
    output logic                 busy,
    output logic [frag_depth:0]  frag_level,
    output logic [fetch_depth:0] fetch_level,
    input  logic                 stat_clear,
    output logic [31:0]          stat_frags,
    output logic [31:0]          stat_fetches
);
    localparam int FRAG_N  = 1 << frag_depth;
    localparam int FETCH_N = 1 << fetch_depth;

    typedef struct packed {
        logic [fml_depth-2:0]   dadr;
        logic [cache_depth-1:0] tadra, tadrb, tadrc, tadrd;
        logic [5:0]             x_frac, y_frac;
        logic [3:0]             miss;
    } frag_rec_t;

    typedef struct packed {
        logic [fml_depth-6:0] tadra, tadrb, tadrc, tadrd;
        logic [3:0]           miss;
    } fetch_rec_t;

    frag_rec_t  frag_in, frag_out;
    fetch_rec_t fetch_in, fetch_out;
    logic       accept, any_miss, fetch_push, frag_pop, fetch_pop;
    logic [31:0] stat_frags_q, stat_frags_d, stat_fetches_q, stat_fetches_d;

    // Ack is a pure function of queue state so no stb/ack input reaches it combinationally
    assign bus.pipe_ack_o = (frag_level != FRAG_N[frag_depth:0]) &
                            (fetch_level != FETCH_N[fetch_depth:0]);

    assign any_miss   = bus.miss_a | bus.miss_b | bus.miss_c | bus.miss_d;
    assign accept     = bus.pipe_stb_i & bus.pipe_ack_o;
    assign fetch_push = accept & any_miss;
    assign frag_pop   = bus.frag_pipe_stb_o & bus.frag_pipe_ack_i;
    assign fetch_pop  = bus.fetch_pipe_stb_o & bus.fetch_pipe_ack_i;

    // Record slicing: the fragment side keeps cache-local offsets, the fetch side keeps line addresses
    always_comb begin
        frag_in.dadr   = bus.dadr;
        frag_in.tadra  = bus.tadra[cache_depth-1:0];
        frag_in.tadrb  = bus.tadrb[cache_depth-1:0];
        frag_in.tadrc  = bus.tadrc[cache_depth-1:0];
        frag_in.tadrd  = bus.tadrd[cache_depth-1:0];
        frag_in.x_frac = bus.x_frac;
        frag_in.y_frac = bus.y_frac;
        frag_in.miss   = {bus.miss_a, bus.miss_b, bus.miss_c, bus.miss_d};
        fetch_in.tadra = bus.tadra[fml_depth-1:5];
        fetch_in.tadrb = bus.tadrb[fml_depth-1:5];
        fetch_in.tadrc = bus.tadrc[fml_depth-1:5];
        fetch_in.tadrd = bus.tadrd[fml_depth-1:5];
        fetch_in.miss  = {bus.miss_a, bus.miss_b, bus.miss_c, bus.miss_d};
    end

    tmu2_splitq_fifo #(.W($bits(frag_rec_t)), .D(frag_depth)) u_frag_q (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (accept),
        .dat_i   (frag_in),
        .pop_i   (frag_pop),
        .dat_o   (frag_out),
        .level_o (frag_level)
    );

    tmu2_splitq_fifo #(.W($bits(fetch_rec_t)), .D(fetch_depth)) u_fetch_q (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (fetch_push),
        .dat_i   (fetch_in),
        .pop_i   (fetch_pop),
        .dat_o   (fetch_out),
        .level_o (fetch_level)
    );

    assign bus.frag_pipe_stb_o  = (frag_level != '0);
    assign bus.fetch_pipe_stb_o = (fetch_level != '0);
    assign busy                 = bus.frag_pipe_stb_o | bus.fetch_pipe_stb_o;

    assign bus.frag_dadr   = frag_out.dadr;
    assign bus.frag_tadra  = frag_out.tadra;
    assign bus.frag_tadrb  = frag_out.tadrb;
    assign bus.frag_tadrc  = frag_out.tadrc;
    assign bus.frag_tadrd  = frag_out.tadrd;
    assign bus.frag_x_frac = frag_out.x_frac;
    assign bus.frag_y_frac = frag_out.y_frac;
    assign {bus.frag_miss_a, bus.frag_miss_b, bus.frag_miss_c, bus.frag_miss_d} = frag_out.miss;

    assign bus.fetch_tadra = fetch_out.tadra;
    assign bus.fetch_tadrb = fetch_out.tadrb;
    assign bus.fetch_tadrc = fetch_out.tadrc;
    assign bus.fetch_tadrd = fetch_out.tadrd;
    assign {bus.fetch_miss_a, bus.fetch_miss_b, bus.fetch_miss_c, bus.fetch_miss_d} = fetch_out.miss;

    // Statistics next-state: clear beats a same-cycle increment, counters wrap naturally
    always_comb begin
        stat_frags_d   = stat_frags_q   + {31'd0, accept};
        stat_fetches_d = stat_fetches_q + {31'd0, fetch_push};
        if (stat_clear) begin
            stat_frags_d   = '0;
            stat_fetches_d = '0;
        end
    end

    // Statistics registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            stat_frags_q   <= '0;
            stat_fetches_q <= '0;
        end else begin
            stat_frags_q   <= stat_frags_d;
            stat_fetches_q <= stat_fetches_d;
        end
    end

    assign stat_frags   = stat_frags_q;
    assign stat_fetches = stat_fetches_q;
endmodule

// File: tb/tb_tmu2_splitq.sv
// Directed bench for tmu2_splitq: reset, fork by miss, independent backpressure, stats, reset mid-burst.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each scenario task checks its own expectations inline.
module tb_tmu2_splitq;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        busy;
    logic [2:0]  frag_level;
    logic [2:0]  fetch_level;
    logic        stat_clear;
    logic [31:0] stat_frags;
    logic [31:0] stat_fetches;

    int checks = 0;
    int errors = 0;

    tmu2_splitq_if bus ();

    tmu2_splitq dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .bus          (bus),
        .busy         (busy),
        .frag_level   (frag_level),
        .fetch_level  (fetch_level),
        .stat_clear   (stat_clear),
        .stat_frags   (stat_frags),
        .stat_fetches (stat_fetches)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_rec(input logic [24:0] d, input logic [25:0] a, input logic [25:0] b,
                           input logic [25:0] c, input logic [25:0] e, input logic [3:0] m);
        bus.dadr   = d;
        bus.tadra  = a;
        bus.tadrb  = b;
        bus.tadrc  = c;
        bus.tadrd  = e;
        bus.x_frac = d[5:0];
        bus.y_frac = d[11:6];
        {bus.miss_a, bus.miss_b, bus.miss_c, bus.miss_d} = m;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
        checks++; if (bus.pipe_ack_o !== 1'b1) begin errors++; $display("FAIL reset_ack got %b exp 1", bus.pipe_ack_o); end
        checks++; if (bus.frag_pipe_stb_o !== 1'b0) begin errors++; $display("FAIL reset_frag_stb got %b exp 0", bus.frag_pipe_stb_o); end
        checks++; if (bus.fetch_pipe_stb_o !== 1'b0) begin errors++; $display("FAIL reset_fetch_stb got %b exp 0", bus.fetch_pipe_stb_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frag_level !== 3'd0 || fetch_level !== 3'd0) begin errors++; $display("FAIL reset_levels got %0d/%0d exp 0/0", frag_level, fetch_level); end
        checks++; if (stat_frags !== 32'd0 || stat_fetches !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_frags, stat_fetches); end
    endtask

    task automatic test_single_miss();
        bus.frag_pipe_ack_i  = 1'b0;
        bus.fetch_pipe_ack_i = 1'b0;
        set_rec(25'h0ABCDE, 26'h0000020, 26'h0123456, 26'h0000040, 26'h0000060, 4'b0100);
        bus.pipe_stb_i = 1'b1;
        step();
        bus.pipe_stb_i = 1'b0;
        checks++; if (bus.frag_pipe_stb_o !== 1'b1 || bus.fetch_pipe_stb_o !== 1'b1) begin errors++; $display("FAIL single_stbs got %b/%b exp 1/1", bus.frag_pipe_stb_o, bus.fetch_pipe_stb_o); end
        checks++; if (bus.fetch_tadrb !== 21'h091A2) begin errors++; $display("FAIL single_fetch_tadrb got %h exp 091a2", bus.fetch_tadrb); end
        checks++; if (bus.frag_tadrb !== 13'h1456) begin errors++; $display("FAIL single_frag_tadrb got %h exp 1456", bus.frag_tadrb); end
        checks++; if (bus.frag_dadr !== 25'h0ABCDE || bus.frag_x_frac !== 6'h1E || bus.frag_y_frac !== 6'h33) begin errors++; $display("FAIL single_frag_fields got %h %h %h exp 0abcde 1e 33", bus.frag_dadr, bus.frag_x_frac, bus.frag_y_frac); end
        checks++; if (bus.fetch_miss_b !== 1'b1 || bus.fetch_miss_a !== 1'b0 || bus.frag_miss_b !== 1'b1) begin errors++; $display("FAIL single_miss_flags got %b %b %b exp 1 0 1", bus.fetch_miss_b, bus.fetch_miss_a, bus.frag_miss_b); end
        checks++; if (stat_frags !== 32'd1 || stat_fetches !== 32'd1) begin errors++; $display("FAIL single_stats got %0d/%0d exp 1/1", stat_frags, stat_fetches); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        bus.frag_pipe_ack_i  = 1'b1;
        bus.fetch_pipe_ack_i = 1'b1;
        step();
        bus.frag_pipe_ack_i  = 1'b0;
        bus.fetch_pipe_ack_i = 1'b0;
        checks++; if (frag_level !== 3'd0 || fetch_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got %0d/%0d busy %b exp 0/0 busy 0", frag_level, fetch_level, busy); end
    endtask

    task automatic test_hit_only();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        checks++; if (stat_frags !== 32'd0 || stat_fetches !== 32'd0) begin errors++; $display("FAIL hit_clear got %0d/%0d exp 0/0", stat_frags, stat_fetches); end
        bus.frag_pipe_ack_i  = 1'b1;
        bus.fetch_pipe_ack_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_rec(25'(32'h1000 + i), 26'(32'h400 * i), 26'h0, 26'h0, 26'h0, 4'b0000);
            bus.pipe_stb_i = 1'b1;
            step();
            checks++; if (bus.pipe_ack_o !== 1'b1 || bus.fetch_pipe_stb_o !== 1'b0) begin errors++; $display("FAIL hit_ack_stb[%0d] got ack %b fetch_stb %b exp 1 0", i, bus.pipe_ack_o, bus.fetch_pipe_stb_o); end
            checks++; if (frag_level !== 3'd1 || bus.frag_dadr !== 25'(32'h1000 + i)) begin errors++; $display("FAIL hit_head[%0d] got lvl %0d dadr %h exp 1 %h", i, frag_level, bus.frag_dadr, 32'h1000 + i); end
        end
        bus.pipe_stb_i = 1'b0;
        step();
        checks++; if (stat_frags !== 32'd10 || stat_fetches !== 32'd0) begin errors++; $display("FAIL hit_stats got %0d/%0d exp 10/0", stat_frags, stat_fetches); end
        checks++; if (fetch_level !== 3'd0 || frag_level !== 3'd0) begin errors++; $display("FAIL hit_levels got %0d/%0d exp 0/0", frag_level, fetch_level); end
        bus.frag_pipe_ack_i = 1'b0;
    endtask

    task automatic test_fetch_full();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        bus.frag_pipe_ack_i  = 1'b1;
        bus.fetch_pipe_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rec(25'(32'h100 + i), 26'((32'hA0 + i) << 5), 26'h0, 26'h0, 26'h0, 4'b1111);
            bus.pipe_stb_i = 1'b1;
            step();
            checks++; if (bus.pipe_ack_o !== (i < 3)) begin errors++; $display("FAIL fetchfull_ack[%0d] got %b exp %b", i, bus.pipe_ack_o, i < 3); end
        end
        checks++; if (fetch_level !== 3'd4 || bus.fetch_tadra !== 21'h0A0) begin errors++; $display("FAIL fetchfull_level got %0d head %h exp 4 0a0", fetch_level, bus.fetch_tadra); end
        set_rec(25'h1FF, 26'h3FFFFE0, 26'h0, 26'h0, 26'h0, 4'b1111);
        step();
        checks++; if (fetch_level !== 3'd4 || frag_level !== 3'd0) begin errors++; $display("FAIL fetchfull_blocked got %0d/%0d exp frag 0 fetch 4", frag_level, fetch_level); end
        checks++; if (stat_frags !== 32'd4 || stat_fetches !== 32'd4) begin errors++; $display("FAIL fetchfull_stats got %0d/%0d exp 4/4", stat_frags, stat_fetches); end
        bus.fetch_pipe_ack_i = 1'b1;
        step();
        bus.fetch_pipe_ack_i = 1'b0;
        bus.pipe_stb_i       = 1'b0;
        checks++; if (bus.pipe_ack_o !== 1'b1 || fetch_level !== 3'd3) begin errors++; $display("FAIL fetchfull_release got ack %b lvl %0d exp 1 3", bus.pipe_ack_o, fetch_level); end
        checks++; if (stat_frags !== 32'd4) begin errors++; $display("FAIL fetchfull_noaccept got %0d exp 4", stat_frags); end
        bus.fetch_pipe_ack_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (bus.fetch_tadra !== 21'(32'hA0 + i)) begin errors++; $display("FAIL fetchfull_order[%0d] got %h exp %h", i, bus.fetch_tadra, 32'hA0 + i); end
            step();
        end
        bus.fetch_pipe_ack_i = 1'b0;
        bus.frag_pipe_ack_i  = 1'b0;
        checks++; if (fetch_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL fetchfull_drained got %0d busy %b exp 0 0", fetch_level, busy); end
    endtask

    task automatic test_frag_full_no_bypass();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        bus.frag_pipe_ack_i  = 1'b0;
        bus.fetch_pipe_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rec(25'(32'h200 + i), 26'h0, 26'h0, 26'h0, 26'h0, 4'b0000);
            bus.pipe_stb_i = 1'b1;
            step();
        end
        checks++; if (frag_level !== 3'd4 || bus.pipe_ack_o !== 1'b0) begin errors++; $display("FAIL fragfull_full got lvl %0d ack %b exp 4 0", frag_level, bus.pipe_ack_o); end
        set_rec(25'h204, 26'h0, 26'h0, 26'h0, 26'h0, 4'b0000);
        bus.frag_pipe_ack_i = 1'b1;
        step();
        bus.frag_pipe_ack_i = 1'b0;
        checks++; if (frag_level !== 3'd3 || stat_frags !== 32'd4) begin errors++; $display("FAIL fragfull_nobypass got lvl %0d cnt %0d exp 3 4", frag_level, stat_frags); end
        checks++; if (bus.frag_dadr !== 25'h201) begin errors++; $display("FAIL fragfull_head got %h exp 201", bus.frag_dadr); end
        step();
        bus.pipe_stb_i = 1'b0;
        checks++; if (frag_level !== 3'd4 || stat_frags !== 32'd5) begin errors++; $display("FAIL fragfull_resume got lvl %0d cnt %0d exp 4 5", frag_level, stat_frags); end
        bus.frag_pipe_ack_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.frag_dadr !== 25'(32'h200 + i)) begin errors++; $display("FAIL fragfull_order[%0d] got %h exp %h", i, bus.frag_dadr, 32'h200 + i); end
            step();
        end
        bus.frag_pipe_ack_i = 1'b0;
        checks++; if (frag_level !== 3'd0) begin errors++; $display("FAIL fragfull_drained got %0d exp 0", frag_level); end
    endtask

    task automatic test_stat_clear();
        set_rec(25'h333, 26'h0000100, 26'h0, 26'h0, 26'h0, 4'b1000);
        bus.pipe_stb_i = 1'b1;
        stat_clear     = 1'b1;
        step();
        stat_clear = 1'b0;
        checks++; if (stat_frags !== 32'd0 || stat_fetches !== 32'd0) begin errors++; $display("FAIL clear_wins got %0d/%0d exp 0/0", stat_frags, stat_fetches); end
        checks++; if (frag_level !== 3'd1 || fetch_level !== 3'd1) begin errors++; $display("FAIL clear_accepted got %0d/%0d exp 1/1", frag_level, fetch_level); end
        step();
        bus.pipe_stb_i = 1'b0;
        checks++; if (stat_frags !== 32'd1 || stat_fetches !== 32'd1) begin errors++; $display("FAIL clear_recount got %0d/%0d exp 1/1", stat_frags, stat_fetches); end
        bus.frag_pipe_ack_i  = 1'b1;
        bus.fetch_pipe_ack_i = 1'b1;
        step();
        step();
        bus.frag_pipe_ack_i  = 1'b0;
        bus.fetch_pipe_ack_i = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_drained got busy %b exp 0", busy); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            set_rec(25'(32'h40 + i), 26'h0, 26'h0, 26'(32'h20 * (i + 1)), 26'h0, 4'b0010);
            bus.pipe_stb_i = 1'b1;
            step();
        end
        bus.pipe_stb_i = 1'b0;
        checks++; if (frag_level !== 3'd3 || fetch_level !== 3'd3) begin errors++; $display("FAIL midrst_fill got %0d/%0d exp 3/3", frag_level, fetch_level); end
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        checks++; if (frag_level !== 3'd0 || fetch_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_levels got %0d/%0d busy %b exp 0/0 0", frag_level, fetch_level, busy); end
        checks++; if (bus.frag_pipe_stb_o !== 1'b0 || bus.fetch_pipe_stb_o !== 1'b0 || bus.pipe_ack_o !== 1'b1) begin errors++; $display("FAIL midrst_stbs got %b %b ack %b exp 0 0 1", bus.frag_pipe_stb_o, bus.fetch_pipe_stb_o, bus.pipe_ack_o); end
        checks++; if (stat_frags !== 32'd0 || stat_fetches !== 32'd0) begin errors++; $display("FAIL midrst_stats got %0d/%0d exp 0/0", stat_frags, stat_fetches); end
        set_rec(25'h77, 26'h0, 26'h0, 26'h3FFFFE0, 26'h0, 4'b0010);
        bus.pipe_stb_i = 1'b1;
        step();
        bus.pipe_stb_i = 1'b0;
        checks++; if (frag_level !== 3'd1 || fetch_level !== 3'd1 || bus.frag_pipe_stb_o !== 1'b1) begin errors++; $display("FAIL midrst_fresh got %0d/%0d stb %b exp 1/1 1", frag_level, fetch_level, bus.frag_pipe_stb_o); end
        checks++; if (bus.fetch_tadrc !== 21'h1FFFFF || bus.frag_tadrc !== 13'h1FE0 || bus.fetch_miss_c !== 1'b1) begin errors++; $display("FAIL midrst_data got %h %h %b exp 1fffff 1fe0 1", bus.fetch_tadrc, bus.frag_tadrc, bus.fetch_miss_c); end
    endtask

    initial begin
        sys_rst_n            = 1'b0;
        stat_clear           = 1'b0;
        bus.pipe_stb_i       = 1'b0;
        bus.frag_pipe_ack_i  = 1'b0;
        bus.fetch_pipe_ack_i = 1'b0;
        set_rec(25'h0, 26'h0, 26'h0, 26'h0, 26'h0, 4'b0000);
        test_reset();
        test_single_miss();
        test_hit_only();
        test_fetch_full();
        test_frag_full_no_bypass();
        test_stat_clear();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
